// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, sequencer state encoding and an op
// classification helper used by every block that decodes op.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b101;  // 110 and 111 also decode as pass-through of a

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_digit_slice.sv
// One DIGIT-wide ALU slice: a ripple chain of full adders (b inverted for SUB)
// plus the bitwise ops. c_top is the carry into the slice's top bit, which on
// the final digit is the carry into the word MSB and feeds overflow detection.
module alu_digit_slice
  import alu_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic [DIGIT-1:0] y,
  output logic             cout,
  output logic             c_top
);

  logic [DIGIT-1:0] sum;
  logic [DIGIT-1:0] b_eff;
  logic             cc;

  // Ripple-carry add of a and the (optionally inverted) b, then op select.
  always_comb begin
    sum   = '0;
    c_top = 1'b0;
    cc    = cin;
    b_eff = (op == OP_SUB) ? ~b : b;
    for (int i = 0; i < DIGIT; i++) begin
      c_top  = cc;
      sum[i] = a[i] ^ b_eff[i] ^ cc;
      cc     = (a[i] & b_eff[i]) | (cc & (a[i] ^ b_eff[i]));
    end
    cout = cc;
    case (op)
      OP_ADD, OP_SUB: y = sum;
      OP_AND:         y = a & b;
      OP_OR:          y = a | b;
      OP_XOR:         y = a ^ b;
      default:        y = a;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Digit-serial ALU: processes DIGIT bits per clock, LSB digit first, reusing
// one alu_digit_slice over N = WIDTH/DIGIT cycles. Visible outputs load only
// on the final digit so no partial values are ever exposed.
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] res_shift;
  logic [2:0]       op_r;
  logic             cy_r;
  logic             last_digit;
  logic [DIGIT-1:0] slice_y;
  logic             slice_cout;
  logic             slice_ctop;

  alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a     (a_sr[DIGIT-1:0]),
    .b     (b_sr[DIGIT-1:0]),
    .cin   (cy_r),
    .op    (op_r),
    .y     (slice_y),
    .cout  (slice_cout),
    .c_top (slice_ctop)
  );

  assign last_digit = (cnt == CW'(N - 1));
  // New digit enters at the top; after N shifts the full result is aligned.
  assign res_shift  = (res_sr >> DIGIT) | (WIDTH'(slice_y) << (WIDTH - DIGIT));
  assign ready      = (state == ST_IDLE);
  assign done       = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)      state_nxt = ST_RUN;
      ST_RUN:  if (last_digit) state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, digit datapath and final result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      op_r     <= OP_ADD;
      cy_r     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            op_r <= op;
            cnt  <= '0;
            cy_r <= (op == OP_SUB);
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_shift;
          cnt    <= cnt + 1'b1;
          if (is_arith(op_r)) cy_r <= slice_cout;
          if (last_digit) begin
            result   <= res_shift;
            zero     <= (res_shift == '0);
            carry    <= is_arith(op_r) ? slice_cout : 1'b0;
            overflow <= is_arith(op_r) ? (slice_cout ^ slice_ctop) : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
